// File: rtl/player_controller_if.sv
`default_nettype none
// ============================================================================
// player_controller_if : game-tick, button and physics handshake bundle
// Rev 1.0
// ============================================================================
interface player_controller_if;
    logic [1:0] game_tick;
    logic       btn_jump_raw;
    logic       btn_down_raw;
    logic       jump_done;
    logic       collision;
    logic       jump_pulse;
    logic       button_down;
    logic [2:0] player_state;
    logic       run_frame;
    logic       game_start;

    modport master (
        output game_tick, btn_jump_raw, btn_down_raw, jump_done, collision,
        input  jump_pulse, button_down, player_state, run_frame, game_start
    );

    modport slave (
        input  game_tick, btn_jump_raw, btn_down_raw, jump_done, collision,
        output jump_pulse, button_down, player_state, run_frame, game_start
    );
endinterface
`default_nettype wire

// File: rtl/player_controller.sv
`default_nettype none
// ============================================================================
// player_controller : button debounce and IDLE/RUN/DUCK/JUMP/DEAD player FSM
// Rev 1.0
// ============================================================================
module player_controller #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int DB_W            = 10,
    parameter int ANIM_TICKS      = 6
) (
    input  wire logic           clk,
    input  wire logic           reset,
    player_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_DUCK = 3'd2,
        ST_JUMP = 3'd3,
        ST_DEAD = 3'd4
    } state_t;

    localparam int c_AW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;

    logic [1:0] w_raw;
    logic [1:0] w_db;

    assign w_raw = {bus.btn_down_raw, bus.btn_jump_raw};

    // index 0 = jump button, index 1 = down button
    generate
        for (genvar i = 0; i < 2; i++) begin : g_debounce
            logic            r_sync1;
            logic            r_sync2;
            logic            r_db;
            logic [DB_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_db    <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[i];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_db  <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_db[i] = r_db;
        end
    endgenerate

    state_t            r_state;
    logic              r_jump_req;
    logic              r_game_start;
    logic              r_jump_db_d;
    logic [c_AW-1:0]   r_anim_cnt;
    logic              r_run_frame;

    logic w_jump_rise;
    logic w_tick0;
    logic w_tick1;
    logic w_launch;

    assign w_jump_rise = w_db[0] & ~r_jump_db_d;
    // A coincident velocity strobe masks the position strobe
    assign w_tick0     = bus.game_tick[0];
    assign w_tick1     = bus.game_tick[1] & ~bus.game_tick[0];
    assign w_launch    = (r_state == ST_RUN) & r_jump_req & w_tick0 & ~w_db[1] & ~bus.collision;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_jump_req   <= 1'b0;
            r_game_start <= 1'b0;
            r_jump_db_d  <= 1'b0;
        end else begin
            r_jump_db_d  <= w_db[0];
            r_game_start <= 1'b0;
            if (bus.collision && (r_state != ST_DEAD)) begin
                r_state    <= ST_DEAD;
                r_jump_req <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DEAD: begin
                        if (w_jump_rise) begin
                            r_state      <= ST_RUN;
                            r_game_start <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (w_launch) begin
                            r_state    <= ST_JUMP;
                            r_jump_req <= 1'b0;
                        end else if (w_db[1]) begin
                            r_state    <= ST_DUCK;
                            r_jump_req <= 1'b0;
                        end else if (w_jump_rise) begin
                            r_jump_req <= 1'b1;
                        end
                    end
                    ST_DUCK: begin
                        if (!w_db[1]) begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_JUMP: begin
                        if (w_tick1 && bus.jump_done) begin
                            r_state <= w_db[1] ? ST_DUCK : ST_RUN;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_jump_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Leg animation advances only while the player is on the ground
    always_ff @(posedge clk) begin
        if (reset) begin
            r_anim_cnt  <= '0;
            r_run_frame <= 1'b0;
        end else if (w_tick1 && ((r_state == ST_RUN) || (r_state == ST_DUCK))) begin
            if (r_anim_cnt == c_AW'(ANIM_TICKS - 1)) begin
                r_anim_cnt  <= '0;
                r_run_frame <= ~r_run_frame;
            end else begin
                r_anim_cnt  <= r_anim_cnt + 1'b1;
            end
        end
    end

    assign bus.jump_pulse   = w_launch;
    assign bus.button_down  = w_db[1] & ((r_state == ST_DUCK) | (r_state == ST_JUMP));
    assign bus.player_state = r_state;
    assign bus.run_frame    = r_run_frame;
    assign bus.game_start   = r_game_start;

endmodule
`default_nettype wire

// File: tb/tb_player_controller.sv
`default_nettype none
// ============================================================================
// tb_player_controller : directed self-checking bench for player_controller
// Rev 1.0
// ============================================================================
module tb_player_controller;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    player_controller_if ifc ();

    player_controller #(
        .DEBOUNCE_CYCLES (4),
        .DB_W            (3),
        .ANIM_TICKS      (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance to the sample point just after the next falling edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // From RUN: press jump, fire it on a velocity strobe, land in JUMP
    task automatic launch();
        ifc.btn_jump_raw = 1'b1;
        repeat (8) step();
        ifc.game_tick = 2'b01;
        #1;
        check("launch_pulse", int'(ifc.jump_pulse), 1);
        step();
        ifc.game_tick    = 2'b00;
        ifc.btn_jump_raw = 1'b0;
        check("launch_state", int'(ifc.player_state), 3);
        repeat (8) step();
        check("launch_hold", int'(ifc.player_state), 3);
    endtask

    logic [3:0] frames;

    initial begin
        checks           = 0;
        failures         = 0;
        frames           = 4'b0110;
        reset            = 1'b1;
        ifc.game_tick    = 2'b00;
        ifc.btn_jump_raw = 1'b0;
        ifc.btn_down_raw = 1'b0;
        ifc.jump_done    = 1'b0;
        ifc.collision    = 1'b0;
        repeat (3) step();
        check("rst_state", int'(ifc.player_state), 0);
        check("rst_bdown", int'(ifc.button_down), 0);
        check("rst_frame", int'(ifc.run_frame), 0);
        check("rst_start", int'(ifc.game_start), 0);
        check("rst_pulse", int'(ifc.jump_pulse), 0);
        reset = 1'b0;
        step();

        // Test 1: short glitch dropped, held press starts the game
        ifc.btn_jump_raw = 1'b1;
        repeat (3) step();
        ifc.btn_jump_raw = 1'b0;
        repeat (10) step();
        check("t1_glitch", int'(ifc.player_state), 0);
        ifc.btn_jump_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("t1_pulse", int'(ifc.jump_pulse), 0);
            if (i == 6) check("t1_pre", int'(ifc.player_state), 0);
            if (i == 7) begin
                check("t1_run", int'(ifc.player_state), 1);
                check("t1_start", int'(ifc.game_start), 1);
            end
            if (i == 8) check("t1_start_off", int'(ifc.game_start), 0);
        end
        ifc.btn_jump_raw = 1'b0;
        repeat (8) step();

        // Animation: two position ticks per frame toggle
        for (int i = 0; i < 4; i++) begin
            ifc.game_tick = 2'b10;
            step();
            ifc.game_tick = 2'b00;
            check("anim_frame", int'(ifc.run_frame), int'(frames[i]));
            step();
        end
        check("anim_state", int'(ifc.player_state), 1);

        // Test 2: jump fires on the first velocity strobe after the request
        ifc.btn_jump_raw = 1'b1;
        repeat (4) step();
        ifc.game_tick = 2'b01;
        #1;
        check("t2_early", int'(ifc.jump_pulse), 0);
        step();
        ifc.game_tick = 2'b00;
        repeat (3) step();
        ifc.game_tick = 2'b01;
        #1;
        check("t2_pulse", int'(ifc.jump_pulse), 1);
        step();
        ifc.game_tick    = 2'b00;
        ifc.btn_jump_raw = 1'b0;
        #1;
        check("t2_pulse_off", int'(ifc.jump_pulse), 0);
        check("t2_jump", int'(ifc.player_state), 3);
        ifc.jump_done = 1'b1;
        step();
        check("t2_done_notick", int'(ifc.player_state), 3);
        ifc.game_tick = 2'b11;
        step();
        check("t2_tick_prec", int'(ifc.player_state), 3);
        ifc.game_tick = 2'b10;
        step();
        check("t2_land", int'(ifc.player_state), 1);
        ifc.game_tick = 2'b00;
        ifc.jump_done = 1'b0;
        repeat (6) step();

        // Test 3: fast-drop in JUMP, land into DUCK
        launch();
        ifc.btn_down_raw = 1'b1;
        repeat (5) step();
        check("t3_bd_pre", int'(ifc.button_down), 0);
        step();
        check("t3_bd_jump", int'(ifc.button_down), 1);
        check("t3_still_jump", int'(ifc.player_state), 3);
        ifc.game_tick = 2'b10;
        ifc.jump_done = 1'b1;
        step();
        ifc.game_tick = 2'b00;
        ifc.jump_done = 1'b0;
        check("t3_duck", int'(ifc.player_state), 2);
        check("t3_bd_duck", int'(ifc.button_down), 1);

        // Test 5: jump ignored in DUCK, stray jump_done ignored
        ifc.btn_jump_raw = 1'b1;
        repeat (8) step();
        ifc.game_tick = 2'b01;
        #1;
        check("t5_duck_pulse", int'(ifc.jump_pulse), 0);
        step();
        ifc.game_tick    = 2'b00;
        ifc.btn_jump_raw = 1'b0;
        check("t5_duck_state", int'(ifc.player_state), 2);
        ifc.game_tick = 2'b10;
        ifc.jump_done = 1'b1;
        step();
        check("t5_duck_done", int'(ifc.player_state), 2);
        ifc.game_tick = 2'b00;
        ifc.jump_done = 1'b0;
        repeat (8) step();
        ifc.btn_down_raw = 1'b0;
        repeat (6) step();
        check("t3_rel_pre", int'(ifc.player_state), 2);
        step();
        check("t3_rel_run", int'(ifc.player_state), 1);
        check("t3_rel_bd", int'(ifc.button_down), 0);
        ifc.game_tick = 2'b01;
        #1;
        check("t5_no_stale", int'(ifc.jump_pulse), 0);
        step();
        ifc.game_tick = 2'b00;
        check("t5_run_hold", int'(ifc.player_state), 1);
        ifc.game_tick = 2'b10;
        ifc.jump_done = 1'b1;
        step();
        check("t5_run_done", int'(ifc.player_state), 1);
        check("t5_frame", int'(ifc.run_frame), 1);
        ifc.game_tick = 2'b00;
        ifc.jump_done = 1'b0;

        // Test 4: collision beats a pending jump
        ifc.btn_jump_raw = 1'b1;
        repeat (8) step();
        ifc.btn_jump_raw = 1'b0;
        ifc.game_tick    = 2'b01;
        ifc.collision    = 1'b1;
        #1;
        check("t4_pulse", int'(ifc.jump_pulse), 0);
        step();
        ifc.game_tick = 2'b00;
        ifc.collision = 1'b0;
        check("t4_dead", int'(ifc.player_state), 4);
        check("t4_bd", int'(ifc.button_down), 0);
        repeat (8) step();
        check("t4_dead_hold", int'(ifc.player_state), 4);
        ifc.btn_jump_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 6) check("t4_pre", int'(ifc.player_state), 4);
            if (i == 7) begin
                check("t4_restart", int'(ifc.player_state), 1);
                check("t4_start", int'(ifc.game_start), 1);
            end
            if (i == 8) check("t4_start_off", int'(ifc.game_start), 0);
        end
        ifc.btn_jump_raw = 1'b0;
        ifc.game_tick    = 2'b01;
        #1;
        check("t4_no_forward", int'(ifc.jump_pulse), 0);
        step();
        ifc.game_tick = 2'b00;
        check("t4_run", int'(ifc.player_state), 1);
        repeat (8) step();

        // Test 6: frame holds in JUMP, reset mid-JUMP clears everything
        launch();
        check("t6_frame_jump", int'(ifc.run_frame), 1);
        ifc.game_tick = 2'b10;
        step();
        ifc.game_tick = 2'b00;
        check("t6_frame_hold", int'(ifc.run_frame), 1);
        check("t6_jump", int'(ifc.player_state), 3);
        reset = 1'b1;
        step();
        check("t6_rst_state", int'(ifc.player_state), 0);
        check("t6_rst_frame", int'(ifc.run_frame), 0);
        check("t6_rst_start", int'(ifc.game_start), 0);
        check("t6_rst_bd", int'(ifc.button_down), 0);
        check("t6_rst_pulse", int'(ifc.jump_pulse), 0);
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
